// File: rtl/mar_mdr_mem_unit.sv
// rtl/mar_mdr_mem_unit.sv - MAR/MDR register stage with the SRAM read/write handshake FSM
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS timeout abort that sets a sticky Err.
module mar_mdr_mem_unit #(
   parameter int MIN_ACCESS     = 2,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] BUS,
   input  logic        LD_MAR,
   input  logic        LD_MDR,
   input  logic        MIO_EN,
   input  logic        Mem_Req,
   input  logic        Mem_WE,
   input  logic [15:0] Data_from_SRAM,
   input  logic        Mem_Ready,
   output logic [15:0] MAR,
   output logic [15:0] MDR,
   output logic [15:0] Data_to_SRAM,
   output logic        Mem_CE,
   output logic        Mem_OE,
   output logic        Mem_WR,
   output logic        Busy,
   output logic        Done,
   output logic        Err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       op;
   logic       complete;
   logic       end_access;

   assign complete     = (cnt >= 4'(MIN_ACCESS - 1)) && Mem_Ready;
   assign Data_to_SRAM = MDR;

`ifdef MEM_TIMEOUT_EN
   logic [5:0] tcnt;
   logic       timeout;

   // Fires on the edge that closes the TIMEOUT_CYCLES-th ACCESS cycle.
   assign timeout    = (tcnt >= 6'(TIMEOUT_CYCLES - 1));
   assign end_access = complete || timeout;
`else
   assign end_access = complete;
   assign Err        = 1'b0;
`endif

   // Strobes are registered alongside the state so they change only with it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         MAR    <= 16'h0000;
         MDR    <= 16'h0000;
         cnt    <= 4'h0;
         op     <= 1'b0;
         Mem_CE <= 1'b0;
         Mem_OE <= 1'b0;
         Mem_WR <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         tcnt   <= 6'h00;
         Err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (LD_MAR) MAR <= BUS;
               if (LD_MDR) MDR <= MIO_EN ? Data_from_SRAM : BUS;
               if (Mem_Req) begin
                  op     <= Mem_WE;
                  cnt    <= 4'h0;
                  state  <= ACCESS;
                  Mem_CE <= 1'b1;
                  Mem_OE <= !Mem_WE;
                  Mem_WR <= Mem_WE;
                  Busy   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                  tcnt   <= 6'h00;
                  Err    <= 1'b0;
`endif
               end
            end
            ACCESS: begin
               if (cnt != 4'hF) cnt <= cnt + 4'h1;
`ifdef MEM_TIMEOUT_EN
               if (tcnt != 6'h3F) tcnt <= tcnt + 6'h01;
               if (!complete && timeout) Err <= 1'b1;
`endif
               if (complete && !op) MDR <= Data_from_SRAM;
               if (end_access) begin
                  state  <= DONE;
                  Mem_CE <= 1'b0;
                  Mem_OE <= 1'b0;
                  Mem_WR <= 1'b0;
                  Done   <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               Done  <= 1'b0;
               Busy  <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               Mem_CE <= 1'b0;
               Mem_OE <= 1'b0;
               Mem_WR <= 1'b0;
               Busy   <= 1'b0;
               Done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mar_mdr_mem_unit.sv
// tb/tb_mar_mdr_mem_unit.sv - randomized bench for mar_mdr_mem_unit against a transaction-level model
module tb_mar_mdr_mem_unit;

   localparam int MIN_ACC = 2;
   localparam int TMO     = 32;
`ifdef MEM_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset, LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_WE, Mem_Ready;
   logic [15:0] BUS, Data_from_SRAM;
   logic [15:0] MAR, MDR, Data_to_SRAM;
   logic        Mem_CE, Mem_OE, Mem_WR, Busy, Done, Err;

   mar_mdr_mem_unit #(.MIN_ACCESS(MIN_ACC), .TIMEOUT_CYCLES(TMO)) dut (
      .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
      .MIO_EN(MIO_EN), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
      .Data_from_SRAM(Data_from_SRAM), .Mem_Ready(Mem_Ready),
      .MAR(MAR), .MDR(MDR), .Data_to_SRAM(Data_to_SRAM), .Mem_CE(Mem_CE),
      .Mem_OE(Mem_OE), .Mem_WR(Mem_WR), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // Model: architectural registers plus expected strobes for the current cycle.
   logic [15:0] m_mar = 16'h0, m_mdr = 16'h0;
   logic        m_err = 1'b0;
   logic        exp_ce, exp_oe, exp_wr, exp_busy, exp_done;
   logic        chk_en = 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, expv);
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("MAR", MAR, m_mar);
         chk("MDR", MDR, m_mdr);
         chk("Data_to_SRAM", Data_to_SRAM, m_mdr);
         chk("Mem_CE", {15'h0, Mem_CE}, {15'h0, exp_ce});
         chk("Mem_OE", {15'h0, Mem_OE}, {15'h0, exp_oe});
         chk("Mem_WR", {15'h0, Mem_WR}, {15'h0, exp_wr});
         chk("Busy", {15'h0, Busy}, {15'h0, exp_busy});
         chk("Done", {15'h0, Done}, {15'h0, exp_done});
         chk("Err", {15'h0, Err}, {15'h0, m_err});
      end
   end

   task automatic set_exp(input logic ce, input logic oe, input logic wr,
                          input logic busy, input logic done);
      exp_ce = ce; exp_oe = oe; exp_wr = wr; exp_busy = busy; exp_done = done;
   endtask

   task automatic quiet();
      LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; Mem_Req = 0; Mem_WE = 0; Mem_Ready = 0;
      BUS = 16'h0; Data_from_SRAM = 16'h0;
   endtask

   task automatic junk();
      LD_MAR = 1'($urandom); LD_MDR = 1'($urandom); MIO_EN = 1'($urandom);
      Mem_Req = 1'($urandom); Mem_WE = 1'($urandom); BUS = 16'($urandom);
   endtask

   task automatic idle_cyc(input logic ld_mar, input logic ld_mdr, input logic mio,
                           input logic [15:0] bus, input logic [15:0] dsram);
      quiet();
      LD_MAR = ld_mar; LD_MDR = ld_mdr; MIO_EN = mio; BUS = bus; Data_from_SRAM = dsram;
      Mem_Ready = 1'($urandom);
      @(posedge Clk); #1;
      if (ld_mar) m_mar = bus;
      if (ld_mdr) m_mdr = mio ? dsram : bus;
      set_exp(0, 0, 0, 0, 0);
      quiet();
   endtask

   // One full memory cycle: accept in IDLE, ACCESS cycles per ready vector rv
   // (bit k-1 = Mem_Ready in ACCESS cycle k), DONE, back in IDLE. n = ACCESS cycles.
   task automatic access(input logic we, input logic [63:0] rv, input logic [15:0] rd,
                         input logic ld_mar, input logic ld_mdr, input logic mio,
                         input logic [15:0] bus, output int n);
      bit fin = 0;
      quiet();
      Mem_Req = 1; Mem_WE = we; LD_MAR = ld_mar; LD_MDR = ld_mdr; MIO_EN = mio;
      BUS = bus; Data_from_SRAM = rd; Mem_Ready = 1'($urandom);
      @(posedge Clk); #1;
      if (ld_mar) m_mar = bus;
      if (ld_mdr) m_mdr = mio ? rd : bus;
      m_err = 1'b0;
      set_exp(1, ~we, we, 1, 0);
      n = 0;
      while (!fin && n < 64) begin
         n++;
         junk();
         Mem_Ready = rv[n-1];
         Data_from_SRAM = rd;
         @(posedge Clk); #1;
         if (n >= MIN_ACC && rv[n-1]) begin
            if (!we) m_mdr = rd;
            fin = 1;
         end else if (TMO_EN && n >= TMO) begin
            m_err = 1'b1;
            fin = 1;
         end
         if (fin) set_exp(0, 0, 0, 1, 1);
         else     set_exp(1, ~we, we, 1, 0);
      end
      if (!fin) chk("access_bound", 16'(n), 16'(0));
      junk();
      Mem_Ready = 1'($urandom);
      @(posedge Clk); #1;
      set_exp(0, 0, 0, 0, 0);
      quiet();
   endtask

   initial begin
      int n;
      logic [15:0] keep;
      logic [63:0] rv;
      quiet();
      Reset = 1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset = 0;
      set_exp(0, 0, 0, 0, 0);
      chk_en = 1;
      idle_cyc(0, 0, 0, 16'h0, 16'h0);

      // Register loads from BUS.
      idle_cyc(1, 0, 0, 16'h3001, 16'h5555);
      idle_cyc(0, 1, 0, 16'hBEEF, 16'h5555);
      #3;
      chk("lit_mar", MAR, 16'h3001);
      chk("lit_mdr", Data_to_SRAM, 16'hBEEF);

      // Read, ready held high: minimum ACCESS length.
      idle_cyc(1, 0, 0, 16'h0040, 16'h0);
      access(0, {64{1'b1}}, 16'h1234, 0, 0, 0, 16'h0, n);
      chk("lit_read_cycles", 16'(n), 16'(MIN_ACC));
      chk("lit_read_mdr", m_mdr, 16'h1234);

      // Write, ready only on the 5th ACCESS cycle.
      keep = m_mdr;
      access(1, 64'h10, 16'hA5A5, 1, 0, 0, 16'h0100, n);
      chk("lit_write_cycles", 16'(n), 16'd5);
      chk("lit_write_mdr", m_mdr, keep);

      // Early ready is ignored; completion on the later assertion.
      access(0, 64'h11, 16'h7E57, 0, 0, 0, 16'h0, n);
      chk("lit_early_cycles", 16'(n), 16'd5);

      // Same-cycle load + request uses the new values; MDR from SRAM path.
      access(1, 64'h2, 16'hC0DE, 0, 1, 1, 16'h0, n);
      chk("lit_mio_mdr", m_mdr, 16'hC0DE);

`ifdef MEM_TIMEOUT_EN
      keep = m_mdr;
      access(0, 64'h0, 16'hDEAD, 0, 0, 0, 16'h0, n);
      chk("lit_tmo_cycles", 16'(n), 16'(TMO));
      chk("lit_tmo_err", {15'h0, m_err}, 16'h1);
      chk("lit_tmo_mdr", m_mdr, keep);
      idle_cyc(0, 0, 0, 16'h0, 16'h0);
      access(0, 64'h1 << 31, 16'h3232, 0, 0, 0, 16'h0, n);
      chk("lit_ready32_cycles", 16'(n), 16'(TMO));
      chk("lit_ready32_err", {15'h0, m_err}, 16'h0);
`else
      access(0, 64'h1 << 39, 16'h4040, 0, 0, 0, 16'h0, n);
      chk("lit_long_cycles", 16'(n), 16'd40);
`endif

      // Reset during ACCESS with ready and data present: abort, no Done.
      idle_cyc(1, 0, 0, 16'h1111, 16'h0);
      quiet();
      Mem_Req = 1;
      @(posedge Clk); #1;
      set_exp(1, 1, 0, 1, 0);
      quiet();
      for (int i = 0; i < 2; i++) begin
         @(posedge Clk); #1;
      end
      Reset = 1; Mem_Ready = 1; Data_from_SRAM = 16'hABCD;
      @(posedge Clk); #1;
      m_mar = 16'h0; m_mdr = 16'h0; m_err = 1'b0;
      set_exp(0, 0, 0, 0, 0);
      Reset = 0;
      quiet();
      idle_cyc(0, 0, 0, 16'h0, 16'h0);

      // Randomized traffic, including back-to-back requests.
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0)
            idle_cyc(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         rv = 64'h0;
         for (int b = 0; b < 24; b++) rv[b] = ($urandom_range(0, 2) == 0);
         if (!TMO_EN || $urandom_range(0, 5) != 0) rv[20] = 1'b1;
         else rv = 64'h0;
         access(1'($urandom), rv, 16'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 16'($urandom), n);
      end

      idle_cyc(0, 0, 0, 16'h0, 16'h0);
      #3;
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
